vx_cache_flush_ctrl: RTL and testbench
======================================

VX_CACHE_FLUSH_CTRL -- requirements
Module: VX_cache_flush_ctrl

Interface
REQ-001 SHALL have parameter INSTANCE_ID, default "", trace identifier.
REQ-002 SHALL have parameter CACHE_SIZE, default 4096, cache bytes.
REQ-003 SHALL have parameter LINE_SIZE, default 64, line bytes.
REQ-004 SHALL have parameter NUM_BANKS, default 1, banks (power of two).
REQ-005 SHALL have parameter NUM_WAYS, default 1, associativity.
REQ-006 SHALL have parameter MAX_PENDING, default 4, outstanding line flushes allowed.
REQ-007 SHALL have derived NUM_SETS = CACHE_SIZE/(LINE_SIZE*NUM_BANKS*NUM_WAYS); SET_W = LOG2UP(NUM_SETS); WAY_W = LOG2UP(NUM_WAYS).
REQ-008 SHALL have one clock; reset is synchronous and active-high.
REQ-009 SHALL have ports: clk in 1 clock; reset in 1 sync active-high reset.
REQ-010 SHALL have ports: start_valid in 1 flush request; start_ready out 1 accept (high only in IDLE).
REQ-011 SHALL have ports: core_idle in 1 cache has no in-flight core requests (MSHR empty, queues empty).
REQ-012 SHALL have ports: core_req_block out 1 gate core_bus_if req_ready low.
REQ-013 SHALL have ports: flush_valid out 1; flush_ready in 1; flush_set out SET_W; flush_way out WAY_W (broadcast to all banks).
REQ-014 SHALL have ports: flush_ack in 1 one line fully processed (clean skip or writeback accepted by memory).
REQ-015 SHALL have ports: mem_idle in 1 no memory writes outstanding; done out 1 one-cycle pulse; busy out 1.

Function
REQ-016 SHALL implement states IDLE, DRAIN, WALK, WAIT_WB, DONE.
REQ-017 SHALL move IDLE->DRAIN on start_valid&&start_ready; core_req_block high from the next cycle until leaving DONE.
REQ-018 SHALL move DRAIN->WALK on the first cycle core_idle=1 (minimum one cycle in DRAIN).
REQ-019 SHALL in WALK assert flush_valid iff pending < MAX_PENDING; flush_set/flush_way stable while flush_valid&&!flush_ready.
REQ-020 SHALL on flush fire advance way first, then set ({set,way} counter), wrapping to 0 after (NUM_SETS-1,NUM_WAYS-1).
REQ-021 SHALL move WALK->WAIT_WB on the fire of the last line; counter returns to 0.
REQ-022 SHALL track pending: +1 on flush fire, -1 on flush_ack, unchanged when both occur same cycle; flush_ack with pending=0 ignored (assertion fires).
REQ-023 SHALL move WAIT_WB->DONE when pending=0 and mem_idle=1; DONE->IDLE unconditionally next cycle, done=1 only in DONE.
REQ-024 SHALL hold busy=1 in every state except IDLE; start_valid outside IDLE has no effect.
REQ-025 SHALL register all outputs except start_ready (combinational from state); total flush latency >= NUM_SETS*NUM_WAYS + 3 cycles.

Reset
REQ-026 SHALL on reset set state=IDLE, counter=0, pending=0, flush_valid=0, done=0, busy=0, core_req_block=0, from any state including mid-walk.
REQ-027 SHALL not require flush_ack after reset for lines issued before reset.

Configuration
REQ-028 SHALL with CACHE_FLUSH_PERF_EN defined add output perf_flush_cycles (44 bits), counting cycles with busy=1, cumulative across flushes, cleared by reset.
REQ-029 SHALL without CACHE_FLUSH_PERF_EN have no such port or counter.

Structure
REQ-030 SHALL place flush state enum (3-bit) and CACHE_FLUSH_PERF_W=44 in VX_gpu_pkg.
REQ-031 SHALL use VX_pending_size as the single sub-module for the pending counter (SIZE=MAX_PENDING).
REQ-032 SHALL emit DBG_TRACE_CACHE trace lines per flush fire and on done, prefixed with INSTANCE_ID.

Verification (CACHE_SIZE=4096, LINE_SIZE=64, NUM_BANKS=1, NUM_WAYS=2 -> 32 sets, 64 lines)
REQ-033 SHALL cover: start with core_idle=1, flush_ready=1, flush_ack 1 cycle after each fire, mem_idle=1 -> 64 fires in order (0,0),(0,1),(1,0)...(31,1), done pulses once, busy low the cycle after.
REQ-034 SHALL cover: core_idle held 0 for 10 cycles after start -> no flush_valid, core_req_block=1 throughout, walk begins the cycle after core_idle rises.
REQ-035 SHALL cover: MAX_PENDING=4, flush_ack withheld -> exactly 4 fires then flush_valid=0; one ack -> exactly one further fire.
REQ-036 SHALL cover: flush_ready toggled randomly -> flush_set/flush_way never change while valid&&!ready; total fires=64.
REQ-037 SHALL cover: reset asserted at line 20 of walk -> next cycle state IDLE, all outputs 0; new start then flushes all 64 lines from (0,0).
REQ-038 SHALL cover: mem_idle=0 for 5 cycles after last ack -> done delayed exactly until first cycle with mem_idle=1 +1; with CACHE_FLUSH_PERF_EN perf_flush_cycles equals counted busy cycles.

Source files
------------

// File: rtl/vx_cache_flush_ctrl_pkg.sv
// Shared definitions for the cache flush controller.
//   flush_state_e      : 3-bit flush sequencer state encoding
//   CACHE_FLUSH_PERF_W : width of the optional flush-cycle performance counter
//   log2up()           : ceil(log2(x)), never less than 1 (for index widths)
package vx_cache_flush_ctrl_pkg;

  localparam int unsigned CACHE_FLUSH_PERF_W = 44;

  typedef enum logic [2:0] {
    FLUSH_IDLE    = 3'd0,
    FLUSH_DRAIN   = 3'd1,
    FLUSH_WALK    = 3'd2,
    FLUSH_WAIT_WB = 3'd3,
    FLUSH_DONE    = 3'd4
  } flush_state_e;

  function automatic int unsigned log2up(input int unsigned x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/vx_cache_flush_ctrl_pending_size.sv
// VX_pending_size: occupancy counter for outstanding line flushes.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_incr         : one entry added this cycle
//   i_decr         : one entry retired this cycle (ignored when empty)
//   o_size         : registered occupancy
//   o_size_n       : occupancy after this cycle's update
//   o_empty/o_full : occupancy == 0 / occupancy == SIZE
module VX_pending_size #(
  parameter int unsigned SIZE   = 4,
  parameter int unsigned SIZE_W = $clog2(SIZE + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_incr,
  input  logic              i_decr,
  output logic              o_empty,
  output logic              o_full,
  output logic [SIZE_W-1:0] o_size,
  output logic [SIZE_W-1:0] o_size_n
);

  logic [SIZE_W-1:0] r_size;
  logic              w_decr_eff;

  // A retire with nothing outstanding is dropped so the count cannot wrap.
  assign w_decr_eff = i_decr && (r_size != '0);

  always_comb begin
    o_size_n = r_size;
    if (i_incr && !w_decr_eff) begin
      o_size_n = r_size + SIZE_W'(1);
    end else if (w_decr_eff && !i_incr) begin
      o_size_n = r_size - SIZE_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_size <= '0;
    end else begin
      r_size <= o_size_n;
    end
  end

  assign o_size  = r_size;
  assign o_empty = (r_size == '0);
  assign o_full  = (r_size == SIZE_W'(SIZE));

endmodule

// File: rtl/vx_cache_flush_ctrl.sv
// Cache flush controller: drains core traffic, walks every {set,way} of the
// cache issuing one line flush per handshake (broadcast to all banks), waits
// for all writebacks and for memory to go idle, then pulses done.
//   clk, reset              : clock, synchronous active-high reset
//   start_valid/start_ready : flush request handshake (ready only when idle)
//   core_idle               : cache has no in-flight core requests
//   core_req_block          : holds off new core requests during a flush
//   flush_valid/ready       : line flush handshake, flush_set/flush_way index
//   flush_ack               : one issued line fully processed
//   mem_idle                : no memory writes outstanding
//   done                    : one-cycle completion pulse; busy: not idle
//   perf_flush_cycles       : cumulative busy cycles (CACHE_FLUSH_PERF_EN only)
// Optional feature macro: CACHE_FLUSH_PERF_EN. Debug trace macro: DBG_TRACE_CACHE.
module vx_cache_flush_ctrl
  import vx_cache_flush_ctrl_pkg::*;
#(
  parameter string       INSTANCE_ID = "",
  parameter int unsigned CACHE_SIZE  = 4096,
  parameter int unsigned LINE_SIZE   = 64,
  parameter int unsigned NUM_BANKS   = 1,
  parameter int unsigned NUM_WAYS    = 1,
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned NUM_SETS    = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS),
  parameter int unsigned SET_W       = log2up(NUM_SETS),
  parameter int unsigned WAY_W       = log2up(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             core_idle,
  output logic             core_req_block,
  output logic             flush_valid,
  input  logic             flush_ready,
  output logic [SET_W-1:0] flush_set,
  output logic [WAY_W-1:0] flush_way,
  input  logic             flush_ack,
  input  logic             mem_idle,
  output logic             done,
  output logic             busy
`ifdef CACHE_FLUSH_PERF_EN
  , output logic [CACHE_FLUSH_PERF_W-1:0] perf_flush_cycles
`endif
);

  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

  flush_state_e      r_state;
  logic [SET_W-1:0]  r_set;
  logic [WAY_W-1:0]  r_way;
  logic              r_flush_valid;
  logic              r_done;
  logic              r_busy;
  logic              r_block;

  logic              w_fire;
  logic              w_last;
  logic              w_can_issue;
  logic              w_pend_empty;
  logic              w_pend_full;
  logic [PEND_W-1:0] w_pend;
  logic [PEND_W-1:0] w_pend_n;

  assign w_fire = r_flush_valid && flush_ready;
  assign w_last = (r_set == SET_W'(NUM_SETS - 1)) && (r_way == WAY_W'(NUM_WAYS - 1));

  VX_pending_size #(
    .SIZE   (MAX_PENDING),
    .SIZE_W (PEND_W)
  ) pending_size (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_incr   (w_fire),
    .i_decr   (flush_ack),
    .o_empty  (w_pend_empty),
    .o_full   (w_pend_full),
    .o_size   (w_pend),
    .o_size_n (w_pend_n)
  );

  // flush_valid is registered, so it is computed from next cycle's occupancy
  // to keep it exactly equal to (pending < MAX_PENDING) while walking.
  assign w_can_issue = (w_pend_n < PEND_W'(MAX_PENDING));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FLUSH_IDLE;
      r_set         <= '0;
      r_way         <= '0;
      r_flush_valid <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_block       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        FLUSH_IDLE: begin
          if (start_valid) begin
            r_state <= FLUSH_DRAIN;
            r_busy  <= 1'b1;
            r_block <= 1'b1;
          end
        end
        FLUSH_DRAIN: begin
          if (core_idle) begin
            r_state       <= FLUSH_WALK;
            r_flush_valid <= w_can_issue;
          end
        end
        FLUSH_WALK: begin
          if (w_fire && w_last) begin
            r_set         <= '0;
            r_way         <= '0;
            r_state       <= FLUSH_WAIT_WB;
            r_flush_valid <= 1'b0;
          end else begin
            if (w_fire) begin
              if (r_way == WAY_W'(NUM_WAYS - 1)) begin
                r_way <= '0;
                r_set <= r_set + SET_W'(1);
              end else begin
                r_way <= r_way + WAY_W'(1);
              end
            end
            r_flush_valid <= w_can_issue;
          end
        end
        FLUSH_WAIT_WB: begin
          if (w_pend_empty && mem_idle) begin
            r_state <= FLUSH_DONE;
            r_done  <= 1'b1;
          end
        end
        FLUSH_DONE: begin
          r_state <= FLUSH_IDLE;
          r_busy  <= 1'b0;
          r_block <= 1'b0;
        end
        default: begin
          r_state <= FLUSH_IDLE;
        end
      endcase
    end
  end

  assign start_ready    = (r_state == FLUSH_IDLE);
  assign core_req_block = r_block;
  assign flush_valid    = r_flush_valid;
  assign flush_set      = r_set;
  assign flush_way      = r_way;
  assign done           = r_done;
  assign busy           = r_busy;

`ifdef CACHE_FLUSH_PERF_EN
  logic [CACHE_FLUSH_PERF_W-1:0] r_perf_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cycles <= '0;
    end else if (r_busy) begin
      r_perf_cycles <= r_perf_cycles + CACHE_FLUSH_PERF_W'(1);
    end
  end

  assign perf_flush_cycles = r_perf_cycles;
`else
  // No performance counter in this build.
`endif

`ifdef DBG_TRACE_CACHE
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_fire) begin
        $info("%s: flush set=%0d way=%0d pending=%0d", INSTANCE_ID, r_set, r_way, w_pend);
      end
      if (r_done) begin
        $info("%s: flush done", INSTANCE_ID);
      end
    end
  end
`endif

  // An ack with nothing outstanding is dropped by the counter; flag it.
  assert property (@(posedge clk) disable iff (reset) !(flush_ack && w_pend_empty))
    else $error("%s: flush_ack with no line pending (full=%0b)", INSTANCE_ID, w_pend_full);

endmodule

// File: tb/tb_vx_cache_flush_ctrl.sv
module tb_vx_cache_flush_ctrl;
  import vx_cache_flush_ctrl_pkg::*;

  localparam int unsigned SETS  = 32;
  localparam int unsigned WAYS  = 2;
  localparam int unsigned LINES = SETS * WAYS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic       core_idle = 1'b1;
  logic       core_req_block;
  logic       flush_valid;
  logic       flush_ready = 1'b1;
  logic [4:0] flush_set;
  logic [0:0] flush_way;
  logic       flush_ack = 1'b0;
  logic       mem_idle = 1'b1;
  logic       done;
  logic       busy;
`ifdef CACHE_FLUSH_PERF_EN
  logic [CACHE_FLUSH_PERF_W-1:0] perf_flush_cycles;
`endif

  vx_cache_flush_ctrl #(
    .INSTANCE_ID ("tb"),
    .CACHE_SIZE  (4096),
    .LINE_SIZE   (64),
    .NUM_BANKS   (1),
    .NUM_WAYS    (2),
    .MAX_PENDING (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .core_idle      (core_idle),
    .core_req_block (core_req_block),
    .flush_valid    (flush_valid),
    .flush_ready    (flush_ready),
    .flush_set      (flush_set),
    .flush_way      (flush_way),
    .flush_ack      (flush_ack),
    .mem_idle       (mem_idle),
    .done           (done),
    .busy           (busy)
`ifdef CACHE_FLUSH_PERF_EN
    , .perf_flush_cycles (perf_flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: expected {set,way} per fire, expected fire total per done.
  logic [5:0] exp_fire_q[$];
  int         exp_done_q[$];

  // Monitor-owned state.
  int         fires_since = 0;
  int         busy_cnt = 0;
  logic       last_fire = 1'b0;
  logic       prev_stall = 1'b0;
  logic [4:0] prev_set = '0;
  logic [0:0] prev_way = '0;

  // Responder controls (written by stimulus) and state (responder-owned).
  bit auto_ack = 1'b1;
  bit rand_ready = 1'b0;
  int man_req = 0;
  int man_seen = 0;
  int owed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_fire_q.delete();
        exp_done_q.delete();
        fires_since = 0;
        busy_cnt    = 0;
        last_fire   = 1'b0;
        prev_stall  = 1'b0;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        if (prev_stall) begin
          check("hold_set_way", {flush_set, flush_way}, {prev_set, prev_way});
        end
        if (flush_valid && flush_ready) begin
          if (exp_fire_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_fire: got set=%0d way=%0d, expected no fire", flush_set, flush_way);
          end else begin
            check("fire_order", {flush_set, flush_way}, exp_fire_q.pop_front());
          end
          fires_since++;
        end
        last_fire  = flush_valid && flush_ready;
        prev_stall = flush_valid && !flush_ready;
        prev_set   = flush_set;
        prev_way   = flush_way;
        if (done === 1'b1) begin
          if (exp_done_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done=1, expected 0");
          end else begin
            check("fires_per_flush", fires_since, exp_done_q.pop_front());
          end
          fires_since = 0;
        end
      end
    end
  end

  // Responder: memory-side ack model and flush_ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        owed      = 0;
        man_seen  = man_req;
        flush_ack = 1'b0;
      end else begin
        if (auto_ack && last_fire) owed++;
        owed     += man_req - man_seen;
        man_seen  = man_req;
        if (owed > 0) begin
          flush_ack = 1'b1;
          owed--;
        end else begin
          flush_ack = 1'b0;
        end
        flush_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flush();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        exp_fire_q.push_back({5'(s), 1'(w)});
      end
    end
    exp_done_q.push_back(LINES);
  endtask

  task automatic start_flush();
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_flush_valid"}, flush_valid, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_block"}, core_req_block, 1'b0);
    check({tag, "_start_ready"}, start_ready, 1'b1);
  endtask

  initial begin
    int cyc;
    int done_seen;

    repeat (3) step();
    check_idle_outputs("reset");
    reset = 1'b0;
    step();

    // Full walk with immediate acks: 64 + 3 cycles from accept to done.
    push_flush();
    start_flush();
    check("start_busy", busy, 1'b1);
    check("start_block", core_req_block, 1'b1);
    check("start_ready_low", start_ready, 1'b0);
    wait_done(300, cyc);
    check("flush_latency", cyc, 67);
    step();
    check_idle_outputs("after_done");

    // Drain phase held by core_idle=0 for 10 cycles.
    core_idle = 1'b0;
    push_flush();
    start_flush();
    for (int i = 0; i < 10; i++) begin
      check("drain_no_valid", flush_valid, 1'b0);
      check("drain_block", core_req_block, 1'b1);
      step();
    end
    core_idle = 1'b1;
    step();
    check("walk_starts", flush_valid, 1'b1);
    wait_done(300, cyc);
    step();

    // Pending limit: 4 fires with acks withheld, one ack frees one more.
    auto_ack = 1'b0;
    push_flush();
    start_flush();
    repeat (12) step();
    check("limit_fires", fires_since, 4);
    check("limit_valid_low", flush_valid, 1'b0);
    man_req++;
    repeat (10) step();
    check("one_more_fire", fires_since, 5);
    check("limit_valid_low2", flush_valid, 1'b0);
    auto_ack = 1'b1;
    man_req += 4;
    wait_done(400, cyc);
    step();

    // Random back-pressure on flush_ready.
    rand_ready = 1'b1;
    push_flush();
    start_flush();
    wait_done(3000, cyc);
    rand_ready = 1'b0;
    step();

    // Reset in the middle of the walk, then a clean full flush.
    push_flush();
    start_flush();
    cyc = 0;
    while (fires_since < 20 && cyc < 200) begin
      step();
      cyc++;
    end
    check("reset_point", fires_since, 20);
    reset = 1'b1;
    step();
    check_idle_outputs("mid_reset");
    reset = 1'b0;
    step();
    push_flush();
    start_flush();
    wait_done(300, cyc);
    check("post_reset_latency", cyc, 67);
    step();

    // mem_idle low for 5 cycles after the last ack delays done.
    mem_idle = 1'b0;
    push_flush();
    start_flush();
    done_seen = 0;
    for (int i = 0; i < 71; i++) begin
      step();
      if (done === 1'b1) done_seen++;
    end
    check("no_done_while_mem_busy", done_seen, 0);
    check("busy_while_mem_busy", busy, 1'b1);
    mem_idle = 1'b1;
    step();
    check("done_after_mem_idle", done, 1'b1);
    step();
    check("idle_after_mem_done", busy, 1'b0);
    step();

    check("fire_queue_empty", exp_fire_q.size(), 0);
    check("done_queue_empty", exp_done_q.size(), 0);
`ifdef CACHE_FLUSH_PERF_EN
    check("perf_flush_cycles", perf_flush_cycles, busy_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
